univ_shift_reg: RTL

//  Parametrised universal shift register: parallel load, logical/arithmetic shift, rotate.

---
 rtl/usr_pkg.sv | 33 +++
 rtl/usr_shift_step.sv | 47 ++++
 rtl/univ_shift_reg.sv | 106 ++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes, FSM states
// and a helper that classifies which operations run the multi-cycle shifter.
package usr_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_SHL   = 3'd2,
    OP_SHR   = 3'd3,
    OP_ROL   = 3'd4,
    OP_ROR   = 3'd5,
    OP_ASR   = 3'd6,
    OP_HOLD7 = 3'd7
  } usr_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } usr_state_e;

  function automatic logic is_shift_op(input usr_op_e op);
    logic result;
    result = 1'b0;
    case (op)
      OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR: result = 1'b1;
      default:                                result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit step of the shifter: next register value and the
// bit that falls off the end for the selected operation.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  usr_op_e          op,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        q_next  = {q[WIDTH-2:0], ser_in_r};
        out_bit = q[WIDTH-1];
      end
      OP_SHR: begin
        q_next  = {ser_in_l, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      OP_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ASR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        q_next  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with start/busy/done handshake, one bit per clock.
// Defining USR_PARITY_EN adds a combinational parity output of q.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  output logic [WIDTH-1:0] q,
`ifdef USR_PARITY_EN
  output logic             parity,
`endif
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  usr_state_e       r_state;
  usr_state_e       w_stateNext;
  usr_op_e          r_op;
  usr_op_e          w_opIn;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_amtClamped;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_qNext;
  logic             r_serOut;
  logic             r_done;
  logic             w_outBit;
  logic             w_accept;

  assign w_opIn       = usr_op_e'(op);
  assign w_amtClamped = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .q        (r_q),
    .op       (r_op),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .q_next   (w_qNext),
    .out_bit  (w_outBit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  // Zero-length shifts, HOLD and LOAD finish at the accept edge without entering SHIFT.
  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (is_shift_op(w_opIn) && (w_amtClamped != '0)) w_stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_W'(1)) w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op     <= OP_HOLD;
      r_cnt    <= '0;
      r_q      <= '0;
      r_serOut <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op  <= w_opIn;
        r_cnt <= w_amtClamped;
        if (w_opIn == OP_LOAD) r_q <= par_in;
        if (w_stateNext == IDLE) r_done <= 1'b1;
      end else if (r_state == SHIFT) begin
        r_q      <= w_qNext;
        r_serOut <= w_outBit;
        r_cnt    <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) r_done <= 1'b1;
      end
    end
  end

  assign q       = r_q;
  assign ser_out = r_serOut;
  assign busy    = (r_state == SHIFT);
  assign done    = r_done;

`ifdef USR_PARITY_EN
  assign parity = ^r_q;
`endif

endmodule
